// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of RUN_LEN equal bits on w, with polarity select and a saturating hit count
module run_length_detector #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          w,
    input  logic                          en,
    input  logic [1:0]                    mode,
    input  logic                          clear_count,
    output logic [$clog2(RUN_LEN+1):0]    state,
    output logic                          z,
    output logic                          hit,
    output logic [CNT_W-1:0]              match_count
);
    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(RUN_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0]    r_q, r_d, r_s;
    logic             p_q, p_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic qual(input logic [1:0] m, input logic pol);
        return (m == 2'b00 && pol) || (m == 2'b01 && !pol) || (m == 2'b10);
    endfunction

    // Next run length on a sample, hit detection and saturating count update
    always_comb begin
        r_s   = (r_q == '0 || w != p_q) ? ONE :
                (r_q != FULL)           ? r_q + ONE :
                (OVERLAP != 0)          ? FULL : ONE;
        hit_d = en && r_s == FULL && qual(mode, w);
        r_d   = en ? r_s : r_q;
        p_d   = en ? w : p_q;
        cnt_d = clear_count              ? '0 :
                (hit_d && cnt_q != '1)   ? cnt_q + 1'b1 : cnt_q;
    end

    // Run state, hit pulse and count registers; reset discards any run in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q   <= '0;
            p_q   <= 1'b0;
            hit_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            p_q   <= p_d;
            hit_q <= hit_d;
            cnt_q <= cnt_d;
        end
    end

    assign z           = r_q == FULL && qual(mode, p_q);
    assign state       = {p_q, r_q};
    assign hit         = hit_q;
    assign match_count = cnt_q;
endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor to the lab's binary-encoded sequence detector.
- Detects runs of RUN_LEN consecutive equal bits on serial input w, with selectable polarity (ones, zeros, either, disabled).
- Supports overlapping or non-overlapping hit counting, a sample enable, and a saturating hit counter.
- Sits directly on the serial input path; z, state and match_count drive board LEDs/displays.

Parameters:
- RUN_LEN, 4, run length that constitutes a hit; legal range 2..255.
- CNT_W, 8, width of match_count.
- OVERLAP, 1, 1 = each extra equal bit past RUN_LEN is another hit; 0 = run restarts after each hit.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- w  input  1  serial data bit, sampled on clk rising edge when en=1.
- en  input  1  sample enable.
- mode  input  2  00 ones only, 01 zeros only, 10 either polarity, 11 detection disabled.
- clear_count  input  1  synchronous clear of match_count.
- state  output  CW+1  {p, r}; CW = $clog2(RUN_LEN+1); p = polarity of current run, r = run length.
- z  output  1  Moore detect flag.
- hit  output  1  one-cycle hit pulse.
- match_count  output  CNT_W  saturating hit count.

Behaviour:
- Reset (reset=0, asynchronous): r=0 (IDLE), p=0, z=0, hit=0, match_count=0. Outputs hold these values until the first enabled edge after reset deasserts. Reset mid-run discards the run entirely.
- State register {p, r}:
  - r=0 means IDLE (no bit seen yet).
  - Updates only on clk rising edge with en=1. With en=0, state, z and match_count hold and hit=0.
- Transition on enabled sample w:
  - From IDLE, or when w != p: p<=w, r<=1.
  - When w == p and r < RUN_LEN: r<=r+1.
  - When w == p and r == RUN_LEN: OVERLAP=1 holds r=RUN_LEN; OVERLAP=0 sets r<=1.
- Qualify(p) = (mode==00 & p==1) | (mode==01 & p==0) | (mode==10). mode==11 never qualifies.
- z = (r==RUN_LEN) & Qualify(p).
  - Decoded combinationally from the state register and mode, so there is no extra latency: z rises in the cycle after the edge that samples the RUN_LEN-th equal bit.
  - A mode change affects z immediately.
- Hit event: an enabled sample edge whose next state has r==RUN_LEN and Qualify(next p) is true.
  - This includes every run-extending sample when OVERLAP=1.
- hit is registered: high for exactly the one cycle following a hit-event edge, otherwise 0.
- match_count:
  - On each clock edge, clear_count=1 forces 0; clear_count has priority over a simultaneous hit event.
  - Otherwise a hit event increments match_count, saturating at 2^CNT_W-1 with no wrap.
- State tracking is independent of mode. Runs continue to be tracked while mode==11, so re-enabling detection mid-run shows z immediately if r==RUN_LEN.
- Polarity flip exactly at RUN_LEN (e.g. 0000 then 1): next state is p=1, r=1, and z drops.

Test Plan:
- Reset then RUN_LEN=4, OVERLAP=1, mode=00, w=1 for 6 enabled cycles -> z rises after the 4th edge; hit pulses after edges 4, 5, 6; match_count=3; state={1,4}.
- OVERLAP=0, mode=00, w=1 for 8 cycles -> r sequence 1,2,3,4,1,2,3,4; z high only after edges 4 and 8; match_count=2.
- mode=01, stream 1,0,0,0,0,1 -> z high only after the 5th edge; z drops after the 6th edge (state={1,1}); match_count=1. Same stream with mode=00 gives match_count=0.
- en toggled 1,0,1,0... while w=1 for 8 cycles -> only 4 samples taken; single hit on the 4th enabled sample; state holds during en=0.
- CNT_W=2, OVERLAP=1, mode=10, w=0 for 10 cycles -> match_count saturates at 3. Then clear_count=1 coinciding with a hit -> match_count=0 while the hit pulse still appears.
- Assert reset low asynchronously mid-run (r=3, between clk edges) -> state=0, z=0, hit=0, match_count=0 immediately. The next 3 ones after release produce no hit; the 4th produces one.
